// File: rtl/nvdla_package.sv
// nvdla_package: shared CSB request/response types and master state encoding
package nvdla_package;
  localparam int NVDLA_CSB_ADDR_W = 16;
  localparam int NVDLA_CSB_DATA_W = 32;
  typedef struct packed {
    logic [NVDLA_CSB_ADDR_W-1:0] addr;
    logic [NVDLA_CSB_DATA_W-1:0] wdat;
    logic                        write;
    logic                        wait_intr;
  } csb_req_t;
  typedef struct packed {
    logic [NVDLA_CSB_DATA_W-1:0] rdata;
    logic                        timeout;
    logic                        intr;
  } csb_rsp_t;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_RESP, WAIT_INTR, RSP} csb_master_state_e;
endpackage

// File: rtl/nvdla_intr_sync.sv
// nvdla_intr_sync: 2-flop synchronizer for the NVDLA interrupt with a rising-edge pulse
module nvdla_intr_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic intr_i,
  output logic rise_o
);
  logic [2:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= '0;
    else sync_q <= {sync_q[1:0], intr_i};
  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/nvdla_csb_master.sv
// nvdla_csb_master: issues one CSB transaction per request and returns its response
module nvdla_csb_master
  import nvdla_package::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  csb_req_t                    req_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output csb_rsp_t                    rsp_o,
  output logic                        csb2nvdla_valid_o,
  input  logic                        csb2nvdla_ready_i,
  output logic [NVDLA_CSB_ADDR_W-1:0] csb2nvdla_addr_o,
  output logic [NVDLA_CSB_DATA_W-1:0] csb2nvdla_wdat_o,
  output logic                        csb2nvdla_write_o,
  output logic                        csb2nvdla_nposted_o,
  input  logic                        nvdla2csb_valid_i,
  input  logic [NVDLA_CSB_DATA_W-1:0] nvdla2csb_data_i,
  input  logic                        nvdla2csb_wr_complete_i,
  input  logic                        dla_intr_i,
  output logic                        busy_o
);
  csb_master_state_e state_q, state_d;
  csb_req_t          req_q, req_d;
  csb_rsp_t          rsp_q, rsp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              seen_q, seen_d, clr_q, clr_d;
  logic              intr_rise, resp_evt, expired;

  nvdla_intr_sync u_intr_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .intr_i (dla_intr_i),
    .rise_o (intr_rise)
  );

  assign resp_evt = req_q.write ? nvdla2csb_wr_complete_i : nvdla2csb_valid_i;
  assign expired  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    seen_d  = seen_q | (intr_rise & (state_q inside {REQ, WAIT_RESP, WAIT_INTR}));
    case (state_q)
      IDLE: begin
        seen_d = 1'b0;
        if (req_valid_i) begin
          req_d   = req_i;
          rsp_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        clr_d = clr_q | clear_i;
        cnt_d = '0;
        state_d = csb2nvdla_ready_i ? (clr_d ? IDLE : WAIT_RESP) : REQ;
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (resp_evt) begin
          rsp_d.rdata = req_q.write ? '0 : nvdla2csb_data_i;
          cnt_d       = '0;
          state_d     = req_q.wait_intr ? WAIT_INTR : RSP;
        end else if (expired) begin
          rsp_d.rdata   = '0;
          rsp_d.timeout = 1'b1;
          state_d       = RSP;
        end
      end
      WAIT_INTR: begin
        cnt_d = cnt_q + 1'b1;
        if (seen_q) begin
          rsp_d.intr = 1'b1;
          state_d    = RSP;
        end else if (expired) begin
          rsp_d.rdata   = '0;
          rsp_d.timeout = 1'b1;
          state_d       = RSP;
        end
      end
      RSP: state_d = rsp_ready_i ? IDLE : RSP;
      default: state_d = IDLE;
    endcase
    // A clear never drops a CSB request mid-handshake; it only lands once REQ completes
    if ((clear_i && state_q != REQ) || (state_q == REQ && csb2nvdla_ready_i && clr_d)) begin
      state_d = IDLE;
      req_d   = '0;
      rsp_d   = '0;
      cnt_d   = '0;
      seen_d  = 1'b0;
      clr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      clr_q   <= clr_d;
    end

  assign req_ready_o         = (state_q == IDLE) & ~clear_i;
  assign busy_o              = state_q != IDLE;
  assign rsp_valid_o         = state_q == RSP;
  assign rsp_o               = rsp_valid_o ? rsp_q : '0;
  assign csb2nvdla_valid_o   = state_q == REQ;
  assign csb2nvdla_addr_o    = csb2nvdla_valid_o ? req_q.addr : '0;
  assign csb2nvdla_wdat_o    = csb2nvdla_valid_o ? req_q.wdat : '0;
  assign csb2nvdla_write_o   = csb2nvdla_valid_o & req_q.write;
  assign csb2nvdla_nposted_o = csb2nvdla_valid_o & req_q.write;
endmodule

// File: tb/tb_nvdla_csb_master.sv
// tb_nvdla_csb_master: directed checks of the CSB master with hand-computed expectations
module tb_nvdla_csb_master;
  import nvdla_package::*;
  logic        clk = 0, rst_ni = 0, clear = 0;
  logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0;
  csb_req_t    req = '0;
  csb_rsp_t    rsp;
  logic        csb_valid, csb_ready = 0, csb_write, csb_nposted;
  logic [15:0] csb_addr;
  logic [31:0] csb_wdat, nv_data = 0;
  logic        nv_valid = 0, nv_wr_complete = 0, dla_intr = 0, busy;
  int          total = 0, fails = 0;

  nvdla_csb_master #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_ni),
    .clear_i                 (clear),
    .req_valid_i             (req_valid),
    .req_ready_o             (req_ready),
    .req_i                   (req),
    .rsp_valid_o             (rsp_valid),
    .rsp_ready_i             (rsp_ready),
    .rsp_o                   (rsp),
    .csb2nvdla_valid_o       (csb_valid),
    .csb2nvdla_ready_i       (csb_ready),
    .csb2nvdla_addr_o        (csb_addr),
    .csb2nvdla_wdat_o        (csb_wdat),
    .csb2nvdla_write_o       (csb_write),
    .csb2nvdla_nposted_o     (csb_nposted),
    .nvdla2csb_valid_i       (nv_valid),
    .nvdla2csb_data_i        (nv_data),
    .nvdla2csb_wr_complete_i (nv_wr_complete),
    .dla_intr_i              (dla_intr),
    .busy_o                  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [31:0] d, input logic w, input logic wi);
    req_valid = 1;
    req = {a, d, w, wi};
    tick();
    req_valid = 0;
    req = '0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  logic stable;

  initial begin
    tick(2);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outs", {busy, csb_valid, rsp_valid, csb_write, csb_nposted}, 0);
    chk("rst_rsp", rsp, 0);
    rst_ni = 1;
    tick();
    nv_valid = 1;
    nv_data = 32'hDEAD;
    nv_wr_complete = 1;
    tick();
    nv_valid = 0;
    nv_wr_complete = 0;
    chk("spurious_idle", {busy, rsp_valid}, 0);
    // Read 0x1234, ready after 3 cycles, data 5 cycles later
    send(16'h1234, 32'h0, 0, 0);
    chk("rd_req", {csb_valid, csb_write, csb_nposted, busy, req_ready}, 5'b10010);
    chk("rd_addr", csb_addr, 16'h1234);
    stable = 1;
    repeat (3) begin
      tick();
      stable &= csb_valid && csb_addr == 16'h1234 && !csb_write;
    end
    chk("rd_stable", stable, 1);
    csb_ready = 1;
    tick();
    csb_ready = 0;
    chk("rd_wait_resp", {csb_valid, busy, rsp_valid}, 3'b010);
    tick(4);
    nv_valid = 1;
    nv_data = 32'hCAFEF00D;
    tick();
    nv_valid = 0;
    nv_data = 0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp", rsp, {32'hCAFEF00D, 1'b0, 1'b0});
    finish_rsp();
    chk("rd_done", {rsp_valid, busy, req_ready}, 3'b001);
    // Posted-completion write, no interrupt wait
    send(16'h0040, 32'hA5A5A5A5, 1, 0);
    chk("wr_fields", {csb_valid, csb_write, csb_nposted}, 3'b111);
    chk("wr_addr_wdat", {csb_addr, csb_wdat}, {16'h0040, 32'hA5A5A5A5});
    csb_ready = 1;
    tick();
    csb_ready = 0;
    tick(2);
    nv_wr_complete = 1;
    tick();
    nv_wr_complete = 0;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp", rsp, 0);
    finish_rsp();
    // Interrupt fires while the request is still pending
    send(16'h0044, 32'h1, 1, 1);
    dla_intr = 1;
    tick(3);
    csb_ready = 1;
    tick();
    csb_ready = 0;
    tick();
    nv_wr_complete = 1;
    tick();
    nv_wr_complete = 0;
    chk("intr_wait_state", {rsp_valid, busy}, 2'b01);
    tick();
    chk("intr_rsp_valid", rsp_valid, 1);
    chk("intr_rsp", rsp, {32'h0, 1'b0, 1'b1});
    dla_intr = 0;
    finish_rsp();
    // Read with no response: timeout after 8 cycles in WAIT_RESP
    send(16'h0010, 32'h0, 0, 0);
    csb_ready = 1;
    tick();
    csb_ready = 0;
    tick(7);
    chk("to_not_yet", rsp_valid, 0);
    tick();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp", rsp, {32'h0, 1'b1, 1'b0});
    // Response held while the FSM stalls
    stable = 1;
    repeat (6) begin
      tick();
      stable &= rsp_valid && !req_ready && rsp == {32'h0, 1'b1, 1'b0};
    end
    chk("rsp_hold", stable, 1);
    finish_rsp();
    chk("rsp_hold_done", {rsp_valid, req_ready}, 2'b01);
    // clear in REQ: valid kept until ready, no response afterwards
    send(16'h0020, 32'h0, 0, 0);
    clear = 1;
    tick();
    clear = 0;
    stable = 1;
    repeat (3) begin
      tick();
      stable &= csb_valid && csb_addr == 16'h0020;
    end
    chk("clr_valid_held", stable, 1);
    csb_ready = 1;
    tick();
    csb_ready = 0;
    chk("clr_idle", {busy, csb_valid, req_ready}, 3'b001);
    stable = 1;
    repeat (4) begin
      tick();
      stable &= !rsp_valid && !busy;
    end
    chk("clr_no_rsp", stable, 1);
    // Asynchronous reset in WAIT_RESP
    send(16'h0030, 32'h0, 0, 0);
    csb_ready = 1;
    tick();
    csb_ready = 0;
    tick(2);
    chk("ar_busy_before", busy, 1);
    #2 rst_ni = 0;
    #1;
    chk("ar_outs", {busy, csb_valid, rsp_valid, csb_write, csb_nposted, csb_addr, csb_wdat}, 0);
    chk("ar_rsp", rsp, 0);
    chk("ar_req_ready", req_ready, 1);
    tick();
    rst_ni = 1;
    tick(2);
    chk("ar_stays_idle", {busy, rsp_valid}, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
